// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fp_pkg
//  Purpose : Shared types and helpers for the floating-point adder datapath.
//            Holds the operand class enum, the special-case side-band
//            struct carried down the pipeline, flag bit indices and the
//            operand classification function.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package fp_pkg;

  // Operand class. Subnormals never appear: they are flushed to ZERO.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Bit positions inside out_flags.
  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_INX = 0;

  // Special-case outcome resolved in S1 and carried alongside the datapath.
  typedef struct packed {
    logic nan;        // result is canonical qNaN
    logic inf;        // result is infinity of sign inf_sign
    logic inf_sign;
    logic both_zero;  // both operands were (flushed) zero
    logic zero_sign;  // sign to use when both operands are zero
  } fp_spec_t;

  // Classification from width-independent field summaries, so the same
  // function serves every EXP_W/MAN_W instance.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    fp_class_e cls;
    if (exp_zero)       cls = ZERO;
    else if (!exp_ones) cls = NORM;
    else if (frac_zero) cls = INF;
    else                cls = NAN;
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module  : fp_lzc
//  Purpose : Leading-zero counter. Returns the number of zero bits above
//            the most significant set bit; returns WIDTH for an all-zero
//            input.
//  Ports   : vec    in   WIDTH  value to scan
//            count  out  CW     leading-zero count, CW = clog2(WIDTH+1)
//  Rev     : 1.0  initial release
// ============================================================================
module fp_lzc #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    count
);

  // Scan upward; the last (highest) set bit seen wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : fp_add_pipe
//  Purpose : Four-stage pipelined floating-point adder/subtractor with
//            round-to-nearest-even, special-value handling and a global
//            valid/ready stall. One operation per cycle sustained.
//            S1 unpack/compare/swap, S2 align+sticky, S3 add/sub+LZC,
//            S4 normalise/round/pack (registered outputs).
//  Ports   : clk        in   1  clock, rising edge
//            rst        in   1  asynchronous active-high reset
//            in_valid   in   1  operand pair valid
//            in_ready   out  1  operands accepted this cycle
//            in_a/in_b  in   W  operands {sign,exp,frac}
//            in_sub     in   1  1: A-B, 0: A+B
//            out_valid  out  1  result valid
//            out_ready  in   1  downstream accepts result
//            out_res    out  W  rounded result
//            out_flags  out  3  {invalid, overflow, inexact}
//  Rev     : 1.0  initial release
// ============================================================================
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [2:0]   out_flags
);

  localparam int c_XW      = MAN_W + 4;          // hidden + frac + G,R,S
  localparam int c_SW      = c_XW + 1;           // plus carry-out
  localparam int c_LW      = $clog2(c_SW + 1);
  localparam int c_SH_MAX  = MAN_W + 3;
  localparam int c_EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------- stall
  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------------------------------------------------------- S1
  logic             w_a_s, w_b_s;
  logic [EXP_W-1:0] w_a_e, w_b_e;
  logic [MAN_W-1:0] w_a_f, w_b_f;
  fp_class_e        w_a_cls, w_b_cls;
  logic [W-2:0]     w_a_mag, w_b_mag;
  logic [MAN_W:0]   w_a_m, w_b_m;
  logic             w_a_big;
  fp_spec_t         w_s1_spec;

  assign w_a_s = in_a[W-1];
  assign w_a_e = in_a[W-2:MAN_W];
  assign w_a_f = in_a[MAN_W-1:0];
  assign w_b_s = in_b[W-1] ^ in_sub;
  assign w_b_e = in_b[W-2:MAN_W];
  assign w_b_f = in_b[MAN_W-1:0];

  assign w_a_cls = fp_classify(w_a_e == '0, &w_a_e, w_a_f == '0);
  assign w_b_cls = fp_classify(w_b_e == '0, &w_b_e, w_b_f == '0);

  // Flushed magnitudes: a subnormal compares (and adds) as zero.
  assign w_a_mag = (w_a_cls == ZERO) ? '0 : in_a[W-2:0];
  assign w_b_mag = (w_b_cls == ZERO) ? '0 : in_b[W-2:0];
  assign w_a_m   = (w_a_cls == ZERO) ? '0 : {1'b1, w_a_f};
  assign w_b_m   = (w_b_cls == ZERO) ? '0 : {1'b1, w_b_f};
  assign w_a_big = (w_a_mag >= w_b_mag);

  always_comb begin
    w_s1_spec           = '0;
    w_s1_spec.nan       = (w_a_cls == NAN) || (w_b_cls == NAN) ||
                          ((w_a_cls == INF) && (w_b_cls == INF) && (w_a_s != w_b_s));
    w_s1_spec.inf       = (w_a_cls == INF) || (w_b_cls == INF);
    w_s1_spec.inf_sign  = (w_a_cls == INF) ? w_a_s : w_b_s;
    w_s1_spec.both_zero = (w_a_cls == ZERO) && (w_b_cls == ZERO);
    w_s1_spec.zero_sign = w_a_s & w_b_s;
  end

  logic             r_s1_valid;
  fp_spec_t         r_s1_spec;
  logic             r_s1_sign, r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
  logic [MAN_W:0]   r_s1_big_m, r_s1_sml_m;

  // ---------------------------------------------------------------- S2
  int                  w_sh;
  logic [2*c_XW-1:0]   w_wide;
  logic [c_XW-1:0]     w_aligned;

  always_comb begin
    w_sh      = (int'(r_s1_diff) > c_SH_MAX) ? c_SH_MAX : int'(r_s1_diff);
    // Lower half catches every bit shifted past S for the sticky OR.
    w_wide    = {r_s1_sml_m, 3'b000, {c_XW{1'b0}}} >> w_sh;
    w_aligned = {w_wide[2*c_XW-1:c_XW+1], w_wide[c_XW] | (|w_wide[c_XW-1:0])};
  end

  logic             r_s2_valid;
  fp_spec_t         r_s2_spec;
  logic             r_s2_sign, r_s2_sub;
  logic [EXP_W-1:0] r_s2_exp;
  logic [MAN_W:0]   r_s2_big_m;
  logic [c_XW-1:0]  r_s2_sml;

  // ---------------------------------------------------------------- S3
  // Big operand has the larger magnitude, so the difference never goes negative.
  logic [c_SW-1:0] w_sum;
  logic [c_LW-1:0] w_lzc;

  assign w_sum = r_s2_sub ? ({1'b0, r_s2_big_m, 3'b000} - {1'b0, r_s2_sml})
                          : ({1'b0, r_s2_big_m, 3'b000} + {1'b0, r_s2_sml});

  fp_lzc #(.WIDTH(c_SW)) u_lzc (
    .vec   (w_sum),
    .count (w_lzc)
  );

  logic             r_s3_valid;
  fp_spec_t         r_s3_spec;
  logic             r_s3_sign;
  logic [EXP_W-1:0] r_s3_exp;
  logic [c_SW-1:0]  r_s3_sum;
  logic [c_LW-1:0]  r_s3_lzc;

  // ---------------------------------------------------------------- S4
  logic [c_XW-1:0]   w_n;
  logic [MAN_W+1:0]  w_rnd;
  logic [MAN_W-1:0]  w_frac;
  logic              w_g, w_r, w_s, w_up, w_inx;
  logic signed [31:0] w_e_n, w_e_r;
  logic [W-1:0]      w_res;
  logic [2:0]        w_flags;

  always_comb begin
    w_n     = '0;
    w_e_n   = '0;
    w_e_r   = '0;
    w_frac  = '0;
    w_res   = '0;
    w_flags = '0;

    if (r_s3_sum[c_SW-1]) begin
      // Carry-out: shift right one, folding the dropped bit into sticky.
      w_n   = {r_s3_sum[c_SW-1:2], r_s3_sum[1] | r_s3_sum[0]};
      w_e_n = int'(r_s3_exp) + 1;
    end else begin
      // Left shift only happens after cancellation, where alignment was
      // at most one bit, so no sticky information is lost here.
      w_n   = c_XW'(r_s3_sum << (r_s3_lzc - c_LW'(1)));
      w_e_n = int'(r_s3_exp) - int'(r_s3_lzc) + 1;
    end

    w_g   = w_n[2];
    w_r   = w_n[1];
    w_s   = w_n[0];
    w_inx = w_g | w_r | w_s;
    w_up  = w_g & (w_r | w_s | w_n[3]);
    w_rnd = {1'b0, w_n[c_XW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};

    if (w_rnd[MAN_W+1]) begin
      w_e_r  = w_e_n + 1;
      w_frac = w_rnd[MAN_W:1];
    end else begin
      w_e_r  = w_e_n;
      w_frac = w_rnd[MAN_W-1:0];
    end

    if (r_s3_spec.nan) begin
      w_res            = c_QNAN;
      w_flags[FLG_INV] = 1'b1;
    end else if (r_s3_spec.inf) begin
      w_res = {r_s3_spec.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s3_sum == '0) begin
      // Exact cancellation gives +0; only -0 + -0 keeps the sign.
      w_res = {r_s3_spec.both_zero & r_s3_spec.zero_sign, {(W-1){1'b0}}};
    end else if (w_e_n <= 0) begin
      w_res            = '0;
      w_flags[FLG_INX] = 1'b1;
    end else if (w_e_r >= c_EXP_MAX) begin
      w_res            = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_res            = {r_s3_sign, w_e_r[EXP_W-1:0], w_frac};
      w_flags[FLG_INX] = w_inx;
    end
  end

  // ---------------------------------------------------------------- regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_spec  <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_diff  <= '0;
      r_s1_big_m <= '0;
      r_s1_sml_m <= '0;
      r_s2_valid <= 1'b0;
      r_s2_spec  <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_sub   <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_big_m <= '0;
      r_s2_sml   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_spec  <= '0;
      r_s3_sign  <= 1'b0;
      r_s3_exp   <= '0;
      r_s3_sum   <= '0;
      r_s3_lzc   <= '0;
      out_valid  <= 1'b0;
      out_res    <= '0;
      out_flags  <= '0;
    end else if (w_advance) begin
      // S1
      r_s1_valid <= in_valid;
      r_s1_spec  <= w_s1_spec;
      r_s1_sub   <= w_a_s ^ w_b_s;
      if (w_a_big) begin
        r_s1_sign  <= w_a_s;
        r_s1_exp   <= w_a_e;
        r_s1_diff  <= w_a_e - w_b_e;
        r_s1_big_m <= w_a_m;
        r_s1_sml_m <= w_b_m;
      end else begin
        r_s1_sign  <= w_b_s;
        r_s1_exp   <= w_b_e;
        r_s1_diff  <= w_b_e - w_a_e;
        r_s1_big_m <= w_b_m;
        r_s1_sml_m <= w_a_m;
      end
      // S2
      r_s2_valid <= r_s1_valid;
      r_s2_spec  <= r_s1_spec;
      r_s2_sign  <= r_s1_sign;
      r_s2_sub   <= r_s1_sub;
      r_s2_exp   <= r_s1_exp;
      r_s2_big_m <= r_s1_big_m;
      r_s2_sml   <= w_aligned;
      // S3
      r_s3_valid <= r_s2_valid;
      r_s3_spec  <= r_s2_spec;
      r_s3_sign  <= r_s2_sign;
      r_s3_exp   <= r_s2_exp;
      r_s3_sum   <= w_sum;
      r_s3_lzc   <= w_lzc;
      // S4: bubbles leave the last result on the bus.
      out_valid  <= r_s3_valid;
      if (r_s3_valid) begin
        out_res   <= w_res;
        out_flags <= w_flags;
      end
    end
  end

endmodule
`default_nettype wire
